// File: rtl/pwm_pkg.sv
// Shared widths, dead-time FSM states and the command-to-duty scaling used by
// the PWM dead-time driver.
package pwm_pkg;

  localparam int PWM_DATA_WIDTH = 16;
  localparam int PWM_CNT_WIDTH  = 12;
  localparam int PWM_DT_WIDTH   = 8;

  typedef enum logic [1:0] {
    DT_OFF  = 2'd0,
    DT_WAIT = 2'd1,
    DT_HIGH = 2'd2,
    DT_LOW  = 2'd3
  } dt_state_e;

  // Offset-binary conversion maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1, so the
  // product shifted down by N lands in 0..period-1.
  function automatic logic [PWM_CNT_WIDTH-1:0] duty_scale(
    input logic signed [PWM_DATA_WIDTH-1:0] cmd,
    input logic        [PWM_CNT_WIDTH-1:0]  period
  );
    logic [PWM_DATA_WIDTH-1:0]               offs;
    logic [PWM_DATA_WIDTH+PWM_CNT_WIDTH-1:0] prod;
    offs = {~cmd[PWM_DATA_WIDTH-1], cmd[PWM_DATA_WIDTH-2:0]};
    prod = {{PWM_CNT_WIDTH{1'b0}}, offs} * {{PWM_DATA_WIDTH{1'b0}}, period};
    return prod[PWM_DATA_WIDTH +: PWM_CNT_WIDTH];
  endfunction

endpackage

// File: rtl/pwm_deadtime_driver_if.sv
// Command, configuration, fault and gate-drive signals of the PWM driver.
interface pwm_deadtime_driver_if
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH = PWM_DATA_WIDTH,
  parameter int CNT_WIDTH  = PWM_CNT_WIDTH,
  parameter int DT_WIDTH   = PWM_DT_WIDTH
);
  logic signed [DATA_WIDTH-1:0] cmd;
  logic                         cmd_valid;
  logic        [CNT_WIDTH-1:0]  period;
  logic        [DT_WIDTH-1:0]   deadtime;
  logic                         fault_in;
  logic                         fault_clr;
  logic                         pwm_h;
  logic                         pwm_l;
  logic                         sample_tick;
  logic                         fault_active;
  logic        [CNT_WIDTH-1:0]  duty_active;

  modport master (
    output cmd, cmd_valid, period, deadtime, fault_in, fault_clr,
    input  pwm_h, pwm_l, sample_tick, fault_active, duty_active
  );

  modport slave (
    input  cmd, cmd_valid, period, deadtime, fault_in, fault_clr,
    output pwm_h, pwm_l, sample_tick, fault_active, duty_active
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Dead-time generator: turns the raw PWM level into a non-overlapping
// complementary gate pair with registered outputs.
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_raw,
  input  logic [DT_WIDTH-1:0] i_deadtime,
  input  logic                i_force_off,
  output logic                o_pwm_h,
  output logic                o_pwm_l
);

  dt_state_e           r_state, w_state_nxt, w_target;
  logic [DT_WIDTH-1:0] r_dt_cnt, w_dt_cnt_nxt;
  logic                r_raw_prev;
  logic                w_load;

  always_comb begin
    w_state_nxt  = r_state;
    w_dt_cnt_nxt = r_dt_cnt;
    w_load       = 1'b0;
    w_target     = i_raw ? DT_HIGH : DT_LOW;
    if (i_force_off) begin
      w_state_nxt = DT_OFF;
    end else begin
      unique case (r_state)
        DT_OFF:  w_load = 1'b1;
        // A raw toggle while waiting restarts the dead-time, filtering short pulses
        DT_WAIT: begin
          if (i_raw != r_raw_prev)            w_load = 1'b1;
          else if (r_dt_cnt <= DT_WIDTH'(1))  w_state_nxt = w_target;
          else                                w_dt_cnt_nxt = r_dt_cnt - 1'b1;
        end
        DT_HIGH: w_load = !i_raw;
        DT_LOW:  w_load = i_raw;
        default: w_state_nxt = DT_OFF;
      endcase
      if (w_load) begin
        if (i_deadtime == '0) begin
          w_state_nxt = w_target;
        end else begin
          w_state_nxt  = DT_WAIT;
          w_dt_cnt_nxt = i_deadtime;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= DT_OFF;
      r_dt_cnt   <= '0;
      r_raw_prev <= 1'b0;
      o_pwm_h    <= 1'b0;
      o_pwm_l    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dt_cnt   <= w_dt_cnt_nxt;
      r_raw_prev <= i_raw;
      o_pwm_h    <= (w_state_nxt == DT_HIGH);
      o_pwm_l    <= (w_state_nxt == DT_LOW);
    end
  end

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Edge-aligned PWM with shadowed duty/period, latching fault shutdown and a
// per-period sample tick that paces the upstream PID loop.
module pwm_deadtime_driver
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH = PWM_DATA_WIDTH,
  parameter int CNT_WIDTH  = PWM_CNT_WIDTH,
  parameter int DT_WIDTH   = PWM_DT_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  pwm_deadtime_driver_if.slave  bus
);

  logic        [CNT_WIDTH-1:0]  r_cnt, r_period_act, r_duty_act;
  logic signed [DATA_WIDTH-1:0] r_cmd_pend, r_cmd_last;
  logic                         r_pend, r_fault, r_raw;
  logic                         w_boundary, w_fault_clr, w_force_off;
  logic signed [DATA_WIDTH-1:0] w_cmd_apply;
  logic        [CNT_WIDTH-1:0]  w_duty_next;

  // A zero period is always a boundary so a new nonzero period starts at once
  assign w_boundary  = (r_period_act == '0) || (r_cnt == r_period_act - 1'b1);
  assign w_fault_clr = bus.fault_clr && !bus.fault_in && r_fault;
  assign w_cmd_apply = r_pend ? r_cmd_pend : r_cmd_last;
  assign w_duty_next = duty_scale(w_cmd_apply, bus.period);
  assign w_force_off = bus.fault_in || r_fault || (r_period_act == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_period_act <= '0;
      r_duty_act   <= '0;
      r_cmd_pend   <= '0;
      // Most-negative command scales to zero duty, matching the reset duty
      r_cmd_last   <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
      r_pend       <= 1'b0;
      r_fault      <= 1'b0;
      r_raw        <= 1'b0;
    end else begin
      if (bus.fault_in)       r_fault <= 1'b1;
      else if (bus.fault_clr) r_fault <= 1'b0;

      if (w_fault_clr) begin
        r_cnt <= '0;
      end else if (w_boundary) begin
        r_cnt        <= '0;
        r_period_act <= bus.period;
        r_duty_act   <= w_duty_next;
        r_cmd_last   <= w_cmd_apply;
        r_pend       <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (bus.cmd_valid) begin
        r_cmd_pend <= bus.cmd;
        r_pend     <= 1'b1;
      end

      r_raw <= (r_cnt < r_duty_act) && (r_period_act != '0) && !r_fault;
    end
  end

  assign bus.sample_tick  = (r_cnt == '0) && (r_period_act != '0) && !r_fault;
  assign bus.fault_active = r_fault;
  assign bus.duty_active  = r_duty_act;

  pwm_deadtime_gen #(
    .DT_WIDTH (DT_WIDTH)
  ) u_dt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_raw       (r_raw),
    .i_deadtime  (bus.deadtime),
    .i_force_off (w_force_off),
    .o_pwm_h     (bus.pwm_h),
    .o_pwm_l     (bus.pwm_l)
  );

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed bench for pwm_deadtime_driver: steady-state vector table plus
// hand-written command-timing, period-zero, fault and reset sequences.
module tb_pwm_deadtime_driver;
  import pwm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_deadtime_driver_if bus ();

  pwm_deadtime_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int dt;
    int cmd;
    int duty;
    int h;
    int l;
    int off;
  } vec_t;

  vec_t vecs[6];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cmd       = '0;
    bus.cmd_valid = 1'b0;
    bus.period    = '0;
    bus.deadtime  = '0;
    bus.fault_in  = 1'b0;
    bus.fault_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input int c);
    bus.cmd       = 16'(c);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic measure(input int n, output int h, output int l,
                         output int off, output int both, output int ticks);
    h = 0; l = 0; off = 0; both = 0; ticks = 0;
    repeat (n) begin
      @(negedge clk);
      h     += int'(bus.pwm_h);
      l     += int'(bus.pwm_l);
      off   += int'(!bus.pwm_h && !bus.pwm_l);
      both  += int'(bus.pwm_h && bus.pwm_l);
      ticks += int'(bus.sample_tick);
    end
  endtask

  task automatic wait_tick(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (bus.sample_tick) ok = 1'b1;
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int h, l, off, both, ticks, gap;

    vecs[0] = '{100, 0,      0, 50, 50, 50, 0};
    vecs[1] = '{100, 3,  16384, 75, 72, 22, 6};
    vecs[2] = '{100, 3, -32768,  0,  0,100, 0};
    vecs[3] = '{100, 3,  32767, 99, 96,  0, 4};
    vecs[4] = '{ 10, 0,      0,  5,  5,  5, 0};
    vecs[5] = '{ 10, 3, -16384,  2,  0,  5, 5};

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pwm_h", int'(bus.pwm_h), 0);
    chk("rst_pwm_l", int'(bus.pwm_l), 0);
    chk("rst_tick", int'(bus.sample_tick), 0);
    chk("rst_fault", int'(bus.fault_active), 0);
    chk("rst_duty", int'(bus.duty_active), 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.period   = 12'(vecs[i].period);
      bus.deadtime = 8'(vecs[i].dt);
      strobe(vecs[i].cmd);
      repeat (3 * vecs[i].period + 10) @(negedge clk);
      chk($sformatf("v%0d_duty", i), int'(bus.duty_active), vecs[i].duty);
      measure(vecs[i].period, h, l, off, both, ticks);
      chk($sformatf("v%0d_h", i), h, vecs[i].h);
      chk($sformatf("v%0d_l", i), l, vecs[i].l);
      chk($sformatf("v%0d_off", i), off, vecs[i].off);
      chk($sformatf("v%0d_overlap", i), both, 0);
      chk($sformatf("v%0d_ticks", i), ticks, 1);
    end

    // Mid-period command is held until the next boundary; last strobe wins
    do_reset();
    bus.period   = 12'd100;
    bus.deadtime = 8'd3;
    strobe(-32768);
    repeat (310) @(negedge clk);
    wait_tick("mid_sync");
    repeat (40) @(negedge clk);
    strobe(32767);
    chk("mid_duty_hold", int'(bus.duty_active), 0);
    measure(58, h, l, off, both, ticks);
    chk("mid_h_hold", h, 0);
    wait_tick("mid_next");
    chk("mid_duty_new", int'(bus.duty_active), 99);
    repeat (10) @(negedge clk);
    strobe(0);
    repeat (39) @(negedge clk);
    strobe(-16384);
    chk("lw_duty_hold", int'(bus.duty_active), 99);
    wait_tick("lw_next");
    chk("lw_duty", int'(bus.duty_active), 25);

    // Period zero: no ticks, gates off; nonzero period starts immediately
    do_reset();
    measure(20, h, l, off, both, ticks);
    chk("p0_ticks", ticks, 0);
    chk("p0_gates", h + l, 0);
    bus.period = 12'd10;
    wait_tick("p10_first");
    gap = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      gap++;
      if (bus.sample_tick) break;
    end
    chk("p10_gap", gap, 10);
    measure(50, h, l, off, both, ticks);
    chk("p10_ticks", ticks, 5);

    // Fault shutdown, clear priority and restart with dead-time
    do_reset();
    bus.period = 12'd100;
    strobe(0);
    repeat (310) @(negedge clk);
    wait_tick("flt_sync");
    repeat (30) @(negedge clk);
    chk("flt_pre_h", int'(bus.pwm_h), 1);
    bus.fault_in = 1'b1;
    @(negedge clk);
    bus.fault_in = 1'b0;
    chk("flt_h", int'(bus.pwm_h), 0);
    chk("flt_l", int'(bus.pwm_l), 0);
    chk("flt_active", int'(bus.fault_active), 1);
    measure(150, h, l, off, both, ticks);
    chk("flt_ticks", ticks, 0);
    chk("flt_gates", h + l, 0);
    bus.fault_in  = 1'b1;
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_in  = 1'b0;
    bus.fault_clr = 1'b0;
    @(negedge clk);
    chk("flt_clr_ignored", int'(bus.fault_active), 1);
    bus.deadtime  = 8'd3;
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    chk("clr_active", int'(bus.fault_active), 0);
    chk("clr_tick", int'(bus.sample_tick), 1);
    chk("clr_duty", int'(bus.duty_active), 50);
    measure(4, h, l, off, both, ticks);
    chk("clr_dead_off", h + l, 0);
    @(negedge clk);
    chk("clr_h_on", int'(bus.pwm_h), 1);

    // Asynchronous reset mid-pulse
    wait_tick("rst_sync");
    repeat (20) @(negedge clk);
    chk("arst_pre_h", int'(bus.pwm_h), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_h", int'(bus.pwm_h), 0);
    chk("arst_l", int'(bus.pwm_l), 0);
    chk("arst_duty", int'(bus.duty_active), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
